// File: rtl/controle_reproducao.sv
// Playback/practice sequencer for the FPGAudio datapath: walks one stored song,
// one note per address, decoding every datapath strobe from the state register.
module controle_reproducao #(
  parameter int MAX_ERROS = 7,
  parameter int TEMPO_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               parar,
  input  logic               modo_pratica,
  input  logic               pulso_meio,
  input  logic [TEMPO_W-1:0] memoria_tempo,
  input  logic               fim_musica,
  input  logic               nota_feita,
  input  logic               nota_correta,
  input  logic               fimTF,
  input  logic               fimTempo,
  output logic               zeraC,
  output logic               contaC,
  output logic               zeraR,
  output logic               registraR,
  output logic               registra_erro,
  output logic               leds_mem,
  output logic               ativa_leds,
  output logic               toca,
  output logic               zeraMetro,
  output logic               contaMetro,
  output logic               zeraTF,
  output logic               contaTF,
  output logic               zeraTempo,
  output logic               contaTempo,
  output logic [2:0]         erros,
  output logic               pronto,
  output logic               timeout,
  output logic [3:0]         db_estado
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PREPARA  = 4'd1;
  localparam logic [3:0] S_CARREGA  = 4'd2;
  localparam logic [3:0] S_CHECA    = 4'd3;
  localparam logic [3:0] S_MOSTRA   = 4'd4;
  localparam logic [3:0] S_ESPERA   = 4'd5;
  localparam logic [3:0] S_REGISTRA = 4'd6;
  localparam logic [3:0] S_COMPARA  = 4'd7;
  localparam logic [3:0] S_FEEDBACK = 4'd8;
  localparam logic [3:0] S_PROXIMO  = 4'd9;
  localparam logic [3:0] S_FIM      = 4'd10;
  localparam logic [3:0] S_TIMEOUT  = 4'd11;

  localparam logic [3:0]       MAX_E = 4'(MAX_ERROS);
  localparam logic [TEMPO_W:0] UM    = (TEMPO_W+1)'(1);

  typedef struct packed {
    logic zeraC, contaC, zeraR, registraR, registra_erro;
    logic leds_mem, ativa_leds, toca, zeraMetro, contaMetro;
    logic zeraTF, contaTF, zeraTempo, contaTempo, pronto, timeout;
  } ctrl_t;

  logic [3:0]         estado, prox;
  logic [TEMPO_W-1:0] dur;
  logic               modo;
  logic               nota_ant;
  ctrl_t              ctl;

  logic               nota_sobe, fim_nota, limite;
  logic [TEMPO_W:0]   alvo;
  logic [3:0]         erros_inc;

  assign nota_sobe = nota_feita & ~nota_ant;
  // A zero duration still plays for one half-beat.
  assign alvo      = (memoria_tempo == '0) ? UM : {1'b0, memoria_tempo};
  assign fim_nota  = pulso_meio && (({1'b0, dur} + UM) == alvo);
  assign erros_inc = {1'b0, erros} + 4'd1;
  assign limite    = !nota_correta && (erros_inc >= MAX_E);

  always_comb begin
    prox = estado;
    case (estado)
      S_IDLE:     if (iniciar) prox = S_PREPARA;
      S_PREPARA:  prox = S_CARREGA;
      S_CARREGA:  prox = S_CHECA;
      S_CHECA:    prox = fim_musica ? S_FIM : S_MOSTRA;
      S_MOSTRA:   if (fim_nota) prox = modo ? S_ESPERA : S_PROXIMO;
      S_ESPERA:   if (nota_sobe) prox = S_REGISTRA;
                  else if (fimTempo) prox = S_TIMEOUT;
      S_REGISTRA: prox = S_COMPARA;
      S_COMPARA:  prox = limite ? S_TIMEOUT : S_FEEDBACK;
      S_FEEDBACK: if (fimTF) prox = S_PROXIMO;
      S_PROXIMO:  prox = S_CARREGA;
      S_FIM,
      S_TIMEOUT:  if (iniciar) prox = S_PREPARA;
      default:    prox = S_IDLE;
    endcase
    if (parar) prox = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= S_IDLE;
      dur      <= '0;
      erros    <= '0;
      modo     <= 1'b0;
      nota_ant <= 1'b0;
    end else begin
      estado   <= prox;
      nota_ant <= nota_feita;
      if (parar) erros <= '0;
      else begin
        case (estado)
          S_PREPARA: begin
            erros <= '0;
            modo  <= modo_pratica;
          end
          S_CARREGA: dur <= '0;
          S_MOSTRA:  if (pulso_meio) dur <= dur + 1'b1;
          S_COMPARA: if (!nota_correta && erros != 3'd7) erros <= erros + 3'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ctl = '0;
    case (estado)
      S_PREPARA: begin
        ctl.zeraC = 1'b1; ctl.zeraR = 1'b1; ctl.zeraMetro = 1'b1;
        ctl.zeraTF = 1'b1; ctl.zeraTempo = 1'b1;
      end
      S_CARREGA: begin
        ctl.zeraTempo = 1'b1; ctl.zeraTF = 1'b1;
      end
      S_MOSTRA: begin
        ctl.leds_mem = 1'b1; ctl.ativa_leds = 1'b1;
        ctl.toca = 1'b1; ctl.contaMetro = 1'b1;
      end
      S_ESPERA: begin
        ctl.contaTempo = 1'b1; ctl.contaMetro = 1'b1;
      end
      S_REGISTRA: begin
        ctl.registraR = 1'b1; ctl.registra_erro = 1'b1;
      end
      // Echo of the player's note: LEDs/buzzer fed from the note register.
      S_FEEDBACK: begin
        ctl.ativa_leds = 1'b1; ctl.toca = 1'b1; ctl.contaTF = 1'b1;
      end
      S_PROXIMO: ctl.contaC  = 1'b1;
      S_FIM:     ctl.pronto  = 1'b1;
      S_TIMEOUT: ctl.timeout = 1'b1;
      default: ;
    endcase
  end

  assign {zeraC, contaC, zeraR, registraR, registra_erro,
          leds_mem, ativa_leds, toca, zeraMetro, contaMetro,
          zeraTF, contaTF, zeraTempo, contaTempo, pronto, timeout} = ctl;
  assign db_estado = estado;

endmodule

// File: tb/tb_controle_reproducao.sv
// Bench for controle_reproducao: emulates the datapath (address counter, song RAM,
// timers, key) and checks each run against a note-by-note model of the song.
module tb_controle_reproducao;

  localparam int TF_LEN = 5;
  localparam int TO_LEN = 20;

  logic       clock = 0, reset = 0, iniciar = 0, parar = 0, modo_pratica = 0;
  logic       pulso_meio = 0, nota_feita = 0, nota_correta = 0, to_force = 0;
  logic       fim_musica, fimTF, fimTempo;
  logic [3:0] memoria_tempo;

  logic       a_zeraC, a_contaC, a_zeraR, a_registraR, a_registra_erro, a_leds_mem;
  logic       a_ativa_leds, a_toca, a_zeraMetro, a_contaMetro, a_zeraTF, a_contaTF;
  logic       a_zeraTempo, a_contaTempo, a_pronto, a_timeout;
  logic [2:0] a_erros;
  logic [3:0] a_db_estado;
  logic       b_zeraC, b_contaC, b_zeraR, b_registraR, b_registra_erro, b_leds_mem;
  logic       b_ativa_leds, b_toca, b_zeraMetro, b_contaMetro, b_zeraTF, b_contaTF;
  logic       b_zeraTempo, b_contaTempo, b_pronto, b_timeout;
  logic [2:0] b_erros;
  logic [3:0] b_db_estado;
  logic       m_zeraC, m_contaC, m_zeraR, m_registraR, m_registra_erro, m_leds_mem;
  logic       m_ativa_leds, m_toca, m_zeraMetro, m_contaMetro, m_zeraTF, m_contaTF;
  logic       m_zeraTempo, m_contaTempo, m_pronto, m_timeout;
  logic [2:0] m_erros;
  logic [3:0] m_db_estado;
  logic [22:0] ao, bo, mo;
  logic       sel = 0;

  controle_reproducao dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .modo_pratica(modo_pratica), .pulso_meio(pulso_meio), .memoria_tempo(memoria_tempo),
    .fim_musica(fim_musica), .nota_feita(nota_feita), .nota_correta(nota_correta),
    .fimTF(fimTF), .fimTempo(fimTempo),
    .zeraC(a_zeraC), .contaC(a_contaC), .zeraR(a_zeraR), .registraR(a_registraR),
    .registra_erro(a_registra_erro), .leds_mem(a_leds_mem), .ativa_leds(a_ativa_leds),
    .toca(a_toca), .zeraMetro(a_zeraMetro), .contaMetro(a_contaMetro), .zeraTF(a_zeraTF),
    .contaTF(a_contaTF), .zeraTempo(a_zeraTempo), .contaTempo(a_contaTempo),
    .erros(a_erros), .pronto(a_pronto), .timeout(a_timeout), .db_estado(a_db_estado));

  controle_reproducao #(.MAX_ERROS(2)) dut2 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .modo_pratica(modo_pratica), .pulso_meio(pulso_meio), .memoria_tempo(memoria_tempo),
    .fim_musica(fim_musica), .nota_feita(nota_feita), .nota_correta(nota_correta),
    .fimTF(fimTF), .fimTempo(fimTempo),
    .zeraC(b_zeraC), .contaC(b_contaC), .zeraR(b_zeraR), .registraR(b_registraR),
    .registra_erro(b_registra_erro), .leds_mem(b_leds_mem), .ativa_leds(b_ativa_leds),
    .toca(b_toca), .zeraMetro(b_zeraMetro), .contaMetro(b_contaMetro), .zeraTF(b_zeraTF),
    .contaTF(b_contaTF), .zeraTempo(b_zeraTempo), .contaTempo(b_contaTempo),
    .erros(b_erros), .pronto(b_pronto), .timeout(b_timeout), .db_estado(b_db_estado));

  assign ao = {a_zeraC, a_contaC, a_zeraR, a_registraR, a_registra_erro, a_leds_mem,
               a_ativa_leds, a_toca, a_zeraMetro, a_contaMetro, a_zeraTF, a_contaTF,
               a_zeraTempo, a_contaTempo, a_erros, a_pronto, a_timeout, a_db_estado};
  assign bo = {b_zeraC, b_contaC, b_zeraR, b_registraR, b_registra_erro, b_leds_mem,
               b_ativa_leds, b_toca, b_zeraMetro, b_contaMetro, b_zeraTF, b_contaTF,
               b_zeraTempo, b_contaTempo, b_erros, b_pronto, b_timeout, b_db_estado};
  assign mo = sel ? bo : ao;
  assign {m_zeraC, m_contaC, m_zeraR, m_registraR, m_registra_erro, m_leds_mem,
          m_ativa_leds, m_toca, m_zeraMetro, m_contaMetro, m_zeraTF, m_contaTF,
          m_zeraTempo, m_contaTempo, m_erros, m_pronto, m_timeout, m_db_estado} = mo;

  always #5 clock = ~clock;

  // Song RAM and per-note player plan
  logic [3:0] song_t [0:15];
  int         song_len = 0;
  bit         plan_press [0:15];
  bit         plan_ok    [0:15];
  bit         plan_coll  [0:15];
  int unsigned pm_div = 1;

  // Datapath emulation driven by the selected DUT's strobes
  int addr = 0, tf_cnt = 0, to_cnt = 0;
  always @(posedge clock) begin
    if (m_zeraC) addr <= 0; else if (m_contaC) addr <= (addr + 1) & 15;
    if (m_zeraTF) tf_cnt <= 0; else if (m_contaTF) tf_cnt <= tf_cnt + 1;
    if (m_zeraTempo) to_cnt <= 0; else if (m_contaTempo) to_cnt <= to_cnt + 1;
  end
  assign memoria_tempo = song_t[addr];
  assign fim_musica    = (addr >= song_len);
  assign fimTF         = (tf_cnt >= TF_LEN);
  assign fimTempo      = (to_cnt >= TO_LEN) || to_force;

  // Metronome and player: key pressed on the 3rd cycle of waiting
  int esp_cnt = 0;
  always @(posedge clock) begin
    #1;
    pulso_meio = ($urandom_range(pm_div) == 0);
    if (m_contaTempo) esp_cnt = esp_cnt + 1; else esp_cnt = 0;
    nota_feita = 0;
    to_force   = 0;
    if (m_contaTempo && esp_cnt == 3 && plan_press[addr]) begin
      nota_feita   = 1;
      nota_correta = plan_ok[addr];
      to_force     = plan_coll[addr];
    end
  end

  // Observation: per-note show length in half-beats, feedback lengths, strobe counts
  int cnt_c = 0, cnt_r = 0, cur_p = 0, fb_len = 0;
  bit in_show = 0;
  int show_q[$];
  int fb_q[$];
  always @(negedge clock) begin
    if (m_zeraC) begin
      cnt_c = 0; cnt_r = 0; cur_p = 0; fb_len = 0; in_show = 0;
      show_q.delete(); fb_q.delete();
    end
    if (m_contaC) cnt_c++;
    if (m_registraR) cnt_r++;
    if (m_toca && m_leds_mem) begin
      in_show = 1;
      if (pulso_meio) cur_p++;
    end else if (in_show) begin
      show_q.push_back(cur_p); cur_p = 0; in_show = 0;
    end
    if (m_contaTF) fb_len++;
    else if (fb_len > 0) begin fb_q.push_back(fb_len); fb_len = 0; end
  end

  int n_cmp = 0, n_err = 0;

  task automatic pulse_iniciar();
    @(posedge clock); #1 iniciar = 1;
    @(posedge clock); #1 iniciar = 0;
  endtask

  task automatic do_parar();
    @(posedge clock); #1 parar = 1;
    @(posedge clock); #1 parar = 0;
  endtask

  task automatic set_song(input int len, input int tmax);
    song_len = len;
    for (int i = 0; i < 16; i++) begin
      song_t[i]     = 4'($urandom_range(tmax));
      plan_press[i] = 1; plan_ok[i] = 1; plan_coll[i] = 0;
    end
  endtask

  // Runs one song from iniciar to pronto/timeout and compares with the note-level model.
  task automatic run_and_check(input string name, input bit prat, input int maxe, input bit mid_ini);
    int  e = 0, c = 0, r = 0, fbn = 0;
    bit  exp_to = 0, done = 0, ini_done = 0, p0, t0;
    int  exp_show[$];
    for (int i = 0; i < song_len; i++) begin
      exp_show.push_back(song_t[i] == 0 ? 1 : int'(song_t[i]));
      if (!prat) begin c++; continue; end
      if (!plan_press[i]) begin exp_to = 1; break; end
      r++;
      if (!plan_ok[i]) e++;
      if (e >= maxe) begin exp_to = 1; break; end
      fbn++; c++;
    end
    modo_pratica = prat;
    pulse_iniciar();
    @(posedge clock); #1 modo_pratica = !prat;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge clock);
      if (mid_ini && m_toca && !ini_done) begin iniciar = 1; ini_done = 1; end
      else iniciar = 0;
      if (m_pronto || m_timeout) done = 1;
    end
    iniciar = 0;
    n_cmp++; if (!done) begin n_err++; $display("FAIL %s run_end: got no pronto/timeout, want one within budget", name); end
    n_cmp++; if (m_pronto !== !exp_to) begin n_err++; $display("FAIL %s pronto: got %0b want %0b", name, m_pronto, !exp_to); end
    n_cmp++; if (m_timeout !== exp_to) begin n_err++; $display("FAIL %s timeout: got %0b want %0b", name, m_timeout, exp_to); end
    n_cmp++; if (m_erros !== 3'(e)) begin n_err++; $display("FAIL %s erros: got %0d want %0d", name, m_erros, e); end
    n_cmp++; if (cnt_c !== c) begin n_err++; $display("FAIL %s contaC_pulses: got %0d want %0d", name, cnt_c, c); end
    n_cmp++; if (cnt_r !== r) begin n_err++; $display("FAIL %s registraR_pulses: got %0d want %0d", name, cnt_r, r); end
    n_cmp++;
    if (show_q.size() !== exp_show.size()) begin
      n_err++; $display("FAIL %s notes_shown: got %0d want %0d", name, show_q.size(), exp_show.size());
    end else begin
      foreach (exp_show[i]) begin
        n_cmp++;
        if (show_q[i] !== exp_show[i]) begin
          n_err++; $display("FAIL %s note%0d_halfbeats: got %0d want %0d", name, i, show_q[i], exp_show[i]);
        end
      end
    end
    n_cmp++;
    if (fb_q.size() !== fbn) begin
      n_err++; $display("FAIL %s feedbacks: got %0d want %0d", name, fb_q.size(), fbn);
    end else begin
      foreach (fb_q[i]) begin
        n_cmp++;
        if (fb_q[i] !== TF_LEN + 1) begin
          n_err++; $display("FAIL %s fb%0d_cycles: got %0d want %0d", name, i, fb_q[i], TF_LEN + 1);
        end
      end
    end
    p0 = m_pronto; t0 = m_timeout;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (m_pronto !== !exp_to || m_timeout !== exp_to || m_erros !== 3'(e)) begin
      n_err++; $display("FAIL %s held: got %0b%0b e%0d want %0b%0b e%0d", name, m_pronto, m_timeout, m_erros, p0, t0, e);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++; if (ao !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", ao); end
    n_cmp++; if (bo !== '0) begin n_err++; $display("FAIL reset_outputs_max2: got %h want 0", bo); end
    @(posedge clock); #1 reset = 1;
  endtask

  task automatic test_listen();
    sel = 0; pm_div = 2;
    set_song(3, 0);
    song_t[0] = 4'd2; song_t[1] = 4'd1; song_t[2] = 4'd0;
    run_and_check("listen_fixed", 0, 7, 0);
    run_and_check("listen_restart_from_fim", 0, 7, 1);
    for (int n = 0; n < 3; n++) begin
      pm_div = $urandom_range(2);
      set_song($urandom_range(6, 1), 5);
      run_and_check($sformatf("listen_rand%0d", n), 0, 7, 0);
    end
  endtask

  task automatic test_practice();
    sel = 0; pm_div = 1;
    do_parar();
    set_song(3, 3);
    run_and_check("practice_all_correct", 1, 7, 0);
    for (int n = 0; n < 4; n++) begin
      set_song($urandom_range(9, 2), 3);
      for (int i = 0; i < 16; i++) begin
        plan_ok[i]    = $urandom_range(1);
        plan_press[i] = ($urandom_range(9) != 0);
      end
      run_and_check($sformatf("practice_rand%0d", n), 1, 7, 0);
    end
  endtask

  task automatic test_error_limit();
    do_parar();
    sel = 1; pm_div = 1;
    set_song(4, 2);
    plan_ok[0] = 0; plan_ok[1] = 0;
    run_and_check("max2_two_wrong", 1, 2, 0);
    set_song(5, 2);
    plan_ok[0] = 0; plan_ok[2] = 0;
    run_and_check("max2_wrong_right_wrong", 1, 2, 0);
    do_parar();
    sel = 0;
  endtask

  task automatic test_collision();
    do_parar();
    sel = 0; pm_div = 0;
    set_song(3, 2);
    plan_coll[0] = 1; plan_press[1] = 0;
    run_and_check("timeout_collision", 1, 7, 0);
  endtask

  task automatic test_parar();
    bit seen = 0;
    do_parar();
    sel = 0; pm_div = 3;
    set_song(4, 0);
    for (int i = 0; i < 4; i++) song_t[i] = 4'd15;
    plan_ok[0] = 0;
    modo_pratica = 1;
    pulse_iniciar();
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clock);
      if (a_toca && a_leds_mem && a_erros == 3'd1) seen = 1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL parar_setup: got no second note, want one within budget"); end
    @(posedge clock); #1 parar = 1;
    @(posedge clock); #1 parar = 0;
    @(negedge clock);
    n_cmp++; if (ao !== '0) begin n_err++; $display("FAIL parar_outputs: got %h want 0", ao); end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    do_parar();
    sel = 0; pm_div = 1;
    set_song(3, 1);
    modo_pratica = 1;
    pulse_iniciar();
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clock);
      if (a_contaTF) seen = 1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL areset_setup: got no feedback, want one within budget"); end
    #2 reset = 0;
    #1;
    n_cmp++; if (ao !== '0) begin n_err++; $display("FAIL areset_outputs: got %h want 0", ao); end
    @(posedge clock); #1 reset = 1;
    set_song(4, 3);
    run_and_check("after_async_reset", 0, 7, 0);
  endtask

  initial begin
    test_reset();
    test_listen();
    test_practice();
    test_error_limit();
    test_collision();
    test_parar();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
